// File: rtl/hwag_pkg.sv
// Shared definitions for the hwag angle-generator front end.
// The edge-select encoding is common to vr_cap_cond and the hwag edge configuration.
package hwag_pkg;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // True when a filtered level change is one the edge selection asks for.
  function automatic logic edge_selected(input logic [1:0] sel,
                                         input logic       rise,
                                         input logic       fall);
    logic want_rise;
    logic want_fall;
    want_rise = (sel == EDGE_RISE) || (sel == EDGE_BOTH);
    want_fall = (sel == EDGE_FALL) || (sel == EDGE_BOTH);
    return (rise && want_rise) || (fall && want_fall);
  endfunction

endpackage

// File: rtl/vr_glitch_filter.sv
// Two-flop synchroniser plus run-length glitch filter for the VR comparator.
// Emits the filtered level and single-cycle rise/fall pulses that coincide with its update.
module vr_glitch_filter #(
  parameter int FW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vr_i,
  input  logic [FW-1:0] filt_len_i,
  output logic          cap_o,
  output logic          rise_o,
  output logic          fall_o
);

  logic          s1_q;
  logic          s2_q;
  logic          cap_q;
  logic          cap_d;
  logic [FW-1:0] fcnt_q;
  logic [FW-1:0] fcnt_d;
  logic [FW:0]   thr;
  logic [FW:0]   run_next;
  logic          change;

  always_comb begin
    cap_d    = cap_q;
    fcnt_d   = '0;
    change   = 1'b0;
    thr      = (filt_len_i == '0) ? (FW+1)'(1) : {1'b0, filt_len_i};
    run_next = {1'b0, fcnt_q} + (FW+1)'(1);
    // Extra bit on the run length keeps the compare safe when filt_len is at its top value.
    if (s2_q != cap_q) begin
      if (run_next >= thr) begin
        cap_d  = s2_q;
        change = 1'b1;
      end else begin
        fcnt_d = run_next[FW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cap_q  <= 1'b0;
      fcnt_q <= '0;
    end else begin
      s1_q   <= vr_i;
      s2_q   <= s1_q;
      cap_q  <= cap_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign cap_o  = cap_q;
  assign rise_o = change & s2_q;
  assign fall_o = change & ~s2_q;

endmodule

// File: rtl/vr_cap_cond.sv
// VR/crank capture conditioner: filtered level to hwag.cap, qualified edge strobe with
// lockout, tooth period measurement in clk cycles and stalled-wheel detection.
module vr_cap_cond
  import hwag_pkg::*;
#(
  parameter int FW = 4,
  parameter int PW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vr_in,
  input  logic [1:0]    edge_sel,
  input  logic [FW-1:0] filt_len,
  input  logic [PW-1:0] lockout,
  output logic          cap,
  output logic          cap_stb,
  output logic [PW-1:0] cap_period,
  output logic          stall
);

  localparam logic [PW-1:0] PMAX = {PW{1'b1}};

  logic          rise;
  logic          fall;
  logic          qual;
  logic          stb_q;
  logic          stb_d;
  logic [PW-1:0] lcnt_q;
  logic [PW-1:0] lcnt_d;
  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;
  logic [PW-1:0] per_q;
  logic [PW-1:0] per_d;
  logic          stall_q;
  logic          stall_d;

  vr_glitch_filter #(
    .FW(FW)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .vr_i      (vr_in),
    .filt_len_i(filt_len),
    .cap_o     (cap),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  assign qual = edge_selected(edge_sel, rise, fall) && (lcnt_q == '0);

  always_comb begin
    lcnt_d  = lcnt_q;
    pcnt_d  = pcnt_q;
    per_d   = per_q;
    stall_d = stall_q;
    stb_d   = qual;

    if (qual) begin
      lcnt_d = lockout;
    end else if (lcnt_q != '0) begin
      lcnt_d = lcnt_q - PW'(1);
    end

    // A saturated counter means the previous strobe is out of range: report the maximum.
    if (qual) begin
      per_d   = (pcnt_q == PMAX) ? PMAX : pcnt_q + PW'(1);
      pcnt_d  = '0;
      stall_d = 1'b0;
    end else if (pcnt_q != PMAX) begin
      pcnt_d = pcnt_q + PW'(1);
      if (pcnt_q + PW'(1) == PMAX) begin
        stall_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stb_q   <= 1'b0;
      lcnt_q  <= '0;
      pcnt_q  <= PMAX;
      per_q   <= '0;
      stall_q <= 1'b1;
    end else begin
      stb_q   <= stb_d;
      lcnt_q  <= lcnt_d;
      pcnt_q  <= pcnt_d;
      per_q   <= per_d;
      stall_q <= stall_d;
    end
  end

  assign cap_stb    = stb_q;
  assign cap_period = per_q;
  assign stall      = stall_q;

endmodule

// File: tb/tb_vr_cap_cond.sv
// Randomised scoreboard bench for vr_cap_cond with an event-level reference model
// (sample windows for the filter, strobe timestamps for lockout and period).
module tb_vr_cap_cond;

  localparam int     FW   = 4;
  localparam int     PW   = 12;
  localparam longint MAXP = (64'd1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          vr_in;
  logic [1:0]    edge_sel;
  logic [FW-1:0] filt_len;
  logic [PW-1:0] lockout;
  logic          cap;
  logic          cap_stb;
  logic [PW-1:0] cap_period;
  logic          stall;

  vr_cap_cond #(.FW(FW), .PW(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .vr_in     (vr_in),
    .edge_sel  (edge_sel),
    .filt_len  (filt_len),
    .lockout   (lockout),
    .cap       (cap),
    .cap_stb   (cap_stb),
    .cap_period(cap_period),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint c;
    longint per;
  } exp_t;

  exp_t   sb_q[$];
  longint cyc       = 0;
  bit     p1        = 0;
  bit     p2        = 0;
  bit     mcap      = 0;
  bit     s2h[64];
  longint last_flip = 0;
  bit     have_l    = 0;
  longint last_l    = 0;
  longint lock_ok   = 0;
  bit     exp_stall = 1;

  always @(posedge clk) begin
    bit     s2;
    int     thr;
    int     run;
    bit     want;
    longint per;
    exp_t   e;
    cyc++;
    if (!rst) begin
      p1 = 0; p2 = 0; mcap = 0;
      last_flip = cyc; have_l = 0; lock_ok = 0; exp_stall = 1;
    end else begin
      s2 = p2; p2 = p1; p1 = vr_in;
      s2h[int'(cyc % 64)] = s2;
      thr = (filt_len == 0) ? 1 : int'(filt_len);
      run = 0;
      for (int k = 0; k < 16; k++) begin
        if (k >= thr || (cyc - k) <= last_flip) break;
        if (s2h[int'((cyc - k) % 64)] == mcap) break;
        run++;
      end
      if (run >= thr) begin
        mcap = s2;
        last_flip = cyc;
        want = s2 ? edge_sel[0] : edge_sel[1];
        if (want && cyc >= lock_ok) begin
          per = !have_l ? MAXP : ((cyc - last_l) < MAXP ? (cyc - last_l) : MAXP);
          e.c = cyc; e.per = per;
          sb_q.push_back(e);
          have_l = 1; last_l = cyc;
          lock_ok = cyc + 1 + longint'(lockout);
        end
      end
      exp_stall = !have_l || (cyc - last_l) >= MAXP;
    end
  end

  // ---------------- monitor ----------------
  int stb_count    = 0;
  int cap_hi_count = 0;

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    check("cap_level", cap, mcap);
    check("stall_flag", stall, exp_stall);
    if (cap) cap_hi_count++;
    if (cap_stb) begin
      stb_count++;
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: cycle %0d period %0d, expected no strobe", cyc, cap_period);
      end else begin
        e = sb_q.pop_front();
        check("strobe_cycle", cyc, e.c);
        check("cap_period", cap_period, e.per);
        $display("strobe cycle=%0d period=%0d expected=%0d", cyc, cap_period, e.per);
      end
    end else if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++; errors++;
      $display("FAIL missing_strobe: got none at cycle %0d, expected period %0d", cyc, e.per);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic level(input bit v, input int n);
    vr_in = v;
    cycles(n);
  endtask

  // One tooth, optionally with a sub-filter-length glitch in each half.
  task automatic tooth(input int hi, input int lo, input bit glitch);
    int g;
    if (glitch && hi > 30) begin
      g = $urandom_range(1, 3);
      level(1, 20); level(0, g); level(1, hi - 20 - g);
    end else level(1, hi);
    if (glitch && lo > 30) begin
      g = $urandom_range(1, 3);
      level(0, 20); level(1, g); level(0, lo - 20 - g);
    end else level(0, lo);
  endtask

  initial begin
    int s0;
    int h0;
    int n;
    rst = 1'b0; vr_in = 1'b0; edge_sel = 2'b01; filt_len = 4'd4; lockout = '0;
    cycles(3);
    rst = 1'b1;

    s0 = stb_count;
    cycles(100);
    check("t1_no_strobe", stb_count - s0, 0);
    check("t1_cap", cap, 0);
    check("t1_stall", stall, 1);

    vr_in = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (cap) begin n = i; break; end
    end
    check("t2_latency", n, 6);
    check("t2_strobe", cap_stb, 1);
    check("t2_period", cap_period, MAXP);
    check("t2_stall", stall, 0);
    @(negedge clk);
    level(1, 30); level(0, 30);

    h0 = cap_hi_count;
    level(1, 3); level(0, 20);
    check("t3_glitch3_cap_hi", cap_hi_count - h0, 0);
    h0 = cap_hi_count;
    level(1, 4); level(0, 20);
    check("t3_pulse4_cap_hi", cap_hi_count - h0, 4);

    s0 = stb_count;
    for (int r = 0; r < 2; r++) begin
      for (int t = 0; t < 58; t++) tooth(64, 64, $urandom_range(0, 3) == 0);
      level(0, 256);
    end
    tooth(64, 64, 1'b0);
    check("t4_strobes", stb_count - s0, 117);

    lockout = PW'(200);
    s0 = stb_count;
    for (int t = 0; t < 12; t++) tooth(64, 64, 1'b0);
    check("t5_strobes", stb_count - s0, 6);

    lockout = '0; edge_sel = 2'b11;
    s0 = stb_count;
    for (int t = 0; t < 10; t++) tooth(64, 64, 1'b0);
    check("t6_strobes", stb_count - s0, 20);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) edge_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) filt_len = FW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) lockout = PW'($urandom_range(0, 300));
      level(~vr_in, $urandom_range(1, 60));
    end

    edge_sel = 2'b01; filt_len = 4'd4; lockout = '0;
    level(0, int'(MAXP) + 100);
    check("t6_stall_after_idle", stall, 1);

    for (int t = 0; t < 3; t++) tooth(64, 64, 1'b0);
    level(1, 30);
    check("t6_cap_before_reset", cap, 1);
    rst = 1'b0;
    #1;
    check("t6_reset_cap", cap, 0);
    check("t6_reset_stb", cap_stb, 0);
    check("t6_reset_stall", stall, 1);
    check("t6_reset_period", cap_period, 0);
    cycles(5);
    rst = 1'b1;
    cycles(20);
    check("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
